// File: rtl/lock_pkg.sv
// Shared types and default timing constants for the lock timer controller.
package lock_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } ctrl_state_e;

  localparam int OPEN_TICKS_D    = 25;
  localparam int LOCKOUT_TICKS_D = 150;
  localparam int MAX_FAILS_D     = 3;
  localparam int CNT_W_D         = 10;

endpackage

// File: rtl/lock_timer_ctrl_if.sv
// Keypad, control-FSM pulse and status bundle of the lock timer controller.
interface lock_timer_ctrl_if;
  import lock_pkg::*;

  logic               newkey_in;
  logic               unlock;
  logic               fail;
  logic               relock;
  logic               newkey_out;
  logic               timeUp;
  logic               relay;
  logic               lockout;
  logic [1:0]         fails_left;
  logic [STATE_W-1:0] ctrl_state;

  modport master (
    output newkey_in, unlock, fail, relock,
    input  newkey_out, timeUp, relay, lockout,
    input  fails_left, ctrl_state
  );

  modport slave (
    input  newkey_in, unlock, fail, relock,
    output newkey_out, timeUp, relay, lockout,
    output fails_left, ctrl_state
  );

endinterface

// File: rtl/lock_timer_ctrl_tick_down_counter.sv
// Loadable down-counter that stops at zero instead of wrapping.
module tick_down_counter #(
  parameter int CNT_W = 10
) (
  input  logic             clk5,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !zero) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/lock_timer_ctrl.sv
// Open-window, fail-count and lockout sequencer beside the lock control FSM.
// Build with LOCK_ESCALATE_EN to double the lockout on repeated lockouts.
module lock_timer_ctrl
  import lock_pkg::*;
#(
  parameter int OPEN_TICKS    = OPEN_TICKS_D,
  parameter int LOCKOUT_TICKS = LOCKOUT_TICKS_D,
  parameter int MAX_FAILS     = MAX_FAILS_D,
  parameter int CNT_W         = CNT_W_D
) (
  input logic              clk5,
  input logic              reset,
  lock_timer_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] OPEN_LD = CNT_W'(OPEN_TICKS - 1);
  localparam logic [2:0]       MAXF    = 3'(MAX_FAILS);

  ctrl_state_e      state, state_n;
  logic [1:0]       fail_cnt, fail_cnt_n;
  logic             time_up, time_up_n;
  logic             load, en, zero;
  logic [CNT_W-1:0] load_val, lo_ld, cnt;

`ifdef LOCK_ESCALATE_EN
  logic [1:0] lock_level, lock_level_n;

  assign lo_ld = CNT_W'((LOCKOUT_TICKS << lock_level) - 1);
`else
  assign lo_ld = CNT_W'(LOCKOUT_TICKS - 1);
`endif

  tick_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk5     (clk5),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .cnt      (cnt),
    .zero     (zero)
  );

  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fail_cnt <= 2'd0;
      time_up  <= 1'b0;
`ifdef LOCK_ESCALATE_EN
      lock_level <= 2'd0;
`endif
    end else begin
      state    <= state_n;
      fail_cnt <= fail_cnt_n;
      time_up  <= time_up_n;
`ifdef LOCK_ESCALATE_EN
      lock_level <= lock_level_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    fail_cnt_n = fail_cnt;
    time_up_n  = 1'b0;
    load       = 1'b0;
    load_val   = '0;
    en         = 1'b0;
`ifdef LOCK_ESCALATE_EN
    lock_level_n = lock_level;
`endif
    unique case (state)
      IDLE: begin
        // fail outranks a same-cycle unlock
        if (bus.fail) begin
          if (({1'b0, fail_cnt} + 3'd1) < MAXF) begin
            fail_cnt_n = fail_cnt + 2'd1;
          end else begin
            state_n    = LOCKOUT;
            load       = 1'b1;
            load_val   = lo_ld;
            fail_cnt_n = MAXF[1:0];
`ifdef LOCK_ESCALATE_EN
            // saturate at 2 so lockouts cap at 4x
            if (lock_level != 2'd2)
              lock_level_n = lock_level + 2'd1;
`endif
          end
        end else if (bus.unlock) begin
          state_n    = OPEN;
          load       = 1'b1;
          load_val   = OPEN_LD;
          fail_cnt_n = 2'd0;
`ifdef LOCK_ESCALATE_EN
          lock_level_n = 2'd0;
`endif
        end
      end
      OPEN: begin
        en = 1'b1;
        if (zero || bus.relock) begin
          state_n   = IDLE;
          load      = 1'b1;
          load_val  = '0;
          time_up_n = 1'b1;
        end
      end
      LOCKOUT: begin
        en = 1'b1;
        if (zero) begin
          state_n    = IDLE;
          fail_cnt_n = 2'd0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.newkey_out = bus.newkey_in & (state == IDLE);
  assign bus.relay      = (state == OPEN);
  assign bus.lockout    = (state == LOCKOUT);
  assign bus.timeUp     = time_up;
  assign bus.fails_left = MAXF[1:0] - fail_cnt;
  assign bus.ctrl_state = state;

  a_idle_cnt_zero: assert property (
    @(posedge clk5) disable iff (!reset)
    (state == IDLE) |-> (cnt == '0)
  );

endmodule

// File: tb/tb_lock_timer_ctrl.sv
// Scoreboard bench for lock_timer_ctrl: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_lock_timer_ctrl;
  import lock_pkg::*;

  logic clk5  = 1'b0;
  logic reset = 1'b0;

  always #5 clk5 = ~clk5;

  lock_timer_ctrl_if bus ();

  lock_timer_ctrl dut (
    .clk5  (clk5),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       nk;
    logic       tu;
    logic       rl;
    logic       lo;
    logic [1:0] fl;
    logic [1:0] st;
    logic [9:0] cnt;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

`ifdef LOCK_ESCALATE_EN
  int len[6] = '{150, 300, 600, 600, 150, 300};
`else
  int len[6] = '{150, 150, 150, 150, 150, 150};
`endif

  logic [17:0] act, req;

  always @(negedge clk5) begin
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {bus.newkey_out, bus.timeUp, bus.relay, bus.lockout,
             bus.fails_left, bus.ctrl_state, dut.cnt};
      req = {e.nk, e.tu, e.rl, e.lo, e.fl, e.st, e.cnt};
      checks++;
      if (act !== req) begin
        errors++;
        $display("FAIL %s t=%0t got nk%b tu%b rl%b lo%b fl%0d st%0d cnt%0d req nk%b tu%b rl%b lo%b fl%0d st%0d cnt%0d",
                 e.nm, $time, act[17], act[16], act[15], act[14],
                 act[13:12], act[11:10], act[9:0], req[17], req[16],
                 req[15], req[14], req[13:12], req[11:10], req[9:0]);
      end
    end
  end

  task automatic drive(input logic nk, ul, fa, rk);
    bus.newkey_in = nk;
    bus.unlock    = ul;
    bus.fail      = fa;
    bus.relock    = rk;
  endtask

  task automatic push(input logic nk, tu, input logic [1:0] fl, st,
                      input logic [9:0] c, input string nm);
    exp_t x;
    x.nk  = nk;
    x.tu  = tu;
    x.rl  = (st == 2'd1);
    x.lo  = (st == 2'd2);
    x.fl  = fl;
    x.st  = st;
    x.cnt = c;
    x.nm  = nm;
    q.push_back(x);
  endtask

  task automatic step(input logic nk, ul, fa, rk, tu,
                      input logic [1:0] fl, st,
                      input logic [9:0] c, input string nm);
    @(posedge clk5);
    #1;
    drive(nk, ul, fa, rk);
    push(nk && (st == 2'd0), tu, fl, st, c, nm);
  endtask

  task automatic open_win(input int relock_at, input int stop_at,
                          input string nm);
    step(0, 1, 0, 0, 0, 2'd3, 2'd0, 10'd0, {nm, "_start"});
    for (int k = 0; k < 25; k++) begin
      step(k == 3, 0, 0, k == relock_at, 0, 2'd3, 2'd1,
           10'(24 - k), {nm, "_open"});
      if (k == relock_at || k == stop_at) break;
    end
    if (stop_at < 0) begin
      step(0, 0, 0, 0, 1, 2'd3, 2'd0, 10'd0, {nm, "_timeup"});
      step(0, 0, 0, 0, 0, 2'd3, 2'd0, 10'd0, {nm, "_after"});
    end
  endtask

  task automatic do_lockout(input bit both, input int n_len,
                            input int n_run, input string nm);
    step(0, 0, 1, 0, 0, 2'd3, 2'd0, 10'd0, {nm, "_f1"});
    step(0, 0, 1, 0, 0, 2'd2, 2'd0, 10'd0, {nm, "_f2"});
    step(1, both, 1, 0, 0, 2'd1, 2'd0, 10'd0, {nm, "_f3"});
    for (int k = 0; k < n_run; k++) begin
      step(1, k == 5, k == 7, k == 9, 0, 2'd0, 2'd2,
           10'(n_len - 1 - k), {nm, "_lock"});
    end
    if (n_run == n_len)
      step(1, 0, 0, 0, 0, 2'd3, 2'd0, 10'd0, {nm, "_end"});
  endtask

  task automatic rst_mid(input string nm);
    @(posedge clk5);
    #1;
    drive(0, 0, 0, 0);
    push(0, 0, 2'd3, 2'd0, 10'd0, {nm, "_async"});
    #2;
    reset = 1'b0;
    for (int k = 0; k < 3; k++)
      step(k == 1, 0, 0, 0, 0, 2'd3, 2'd0, 10'd0, {nm, "_held"});
    @(posedge clk5);
    #1;
    reset = 1'b1;
    push(0, 0, 2'd3, 2'd0, 10'd0, {nm, "_rel"});
    for (int k = 0; k < 2; k++)
      step(0, 0, 0, 0, 0, 2'd3, 2'd0, 10'd0, {nm, "_idle"});
  endtask

  initial begin
    drive(0, 0, 0, 0);
    #400;
    reset = 1'b1;
    step(1, 0, 0, 0, 0, 2'd3, 2'd0, 10'd0, "reset_nk_pass");
    step(0, 0, 0, 0, 0, 2'd3, 2'd0, 10'd0, "reset_idle");
    step(0, 0, 0, 1, 0, 2'd3, 2'd0, 10'd0, "idle_relock_ign");
    step(0, 0, 0, 0, 0, 2'd3, 2'd0, 10'd0, "idle");

    open_win(-1, -1, "open_full");
    open_win(4, -1, "open_relock");

    do_lockout(0, len[0], len[0], "lockA");
    do_lockout(1, len[1], len[1], "lockB_both");
    do_lockout(0, len[2], len[2], "lockC");
    do_lockout(0, len[3], len[3], "lockD");
    open_win(2, -1, "open_clr");
    do_lockout(0, len[4], len[4], "lockE");

    do_lockout(0, len[5], 10, "lockF");
    rst_mid("rst_lock");

    open_win(-1, 6, "openG");
    rst_mid("rst_open");

    open_win(-1, -1, "open_final");

    repeat (3) @(posedge clk5);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d req=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
